// File: rtl/fpdiv_round_pack.sv
// FP32 divider back end: normalize (S1), round and pack (S2) in a 2-deep valid/ready pipeline.
// Define FPDIV_RM_EN to add the rm input with directed rounding modes; the default build is RNE only.
module fpdiv_round_pack #(
    parameter int EXP_W = 10,
    parameter int Q_W   = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [Q_W-1:0]   in_quot,
    input  logic             in_sticky,
    input  logic [2:0]       in_class,
`ifdef FPDIV_RM_EN
    input  logic [2:0]       rm,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_flags
);

    localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(255);

    logic                    s1_valid_q;
    logic                    s1_sign_q;
    logic [2:0]              s1_class_q;
    logic signed [EXP_W-1:0] s1_exp_q;
    logic [22:0]             s1_mant_q;
    logic                    s1_g_q;
    logic                    s1_s_q;
`ifdef FPDIV_RM_EN
    logic [2:0]              s1_rm_q;
`endif

    logic                    s2_valid_q;
    logic [31:0]             out_result_q;
    logic [4:0]              out_flags_q;

    logic                    s1_adv;
    logic                    s2_adv;

    logic [22:0]             n_mant;
    logic                    n_g;
    logic                    n_s;
    logic signed [EXP_W-1:0] n_exp;

    logic                    inc;
    logic                    ovf_max;
    logic                    nx;
    logic [23:0]             mant_sum;
    logic signed [EXP_W-1:0] exp_r;
    logic [31:0]             res_d;
    logic [4:0]              flags_d;

    assign s2_adv     = ~s2_valid_q | out_ready;
    assign s1_adv     = ~s1_valid_q | s2_adv;
    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    // A quotient below 1.0 needs one left shift, which also pulls one more bit into the mantissa.
    always_comb begin
        if (in_quot[25]) begin
            n_mant = in_quot[24:2];
            n_g    = in_quot[1];
            n_s    = in_quot[0] | in_sticky;
            n_exp  = in_exp;
        end else begin
            n_mant = in_quot[23:1];
            n_g    = in_quot[0];
            n_s    = in_sticky;
            n_exp  = in_exp - EXP_W'(1);
        end
    end

    always_comb begin
`ifdef FPDIV_RM_EN
        case (s1_rm_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s1_sign_q & (s1_g_q | s1_s_q);
            3'd3:    inc = ~s1_sign_q & (s1_g_q | s1_s_q);
            3'd4:    inc = s1_g_q;
            default: inc = s1_g_q & (s1_s_q | s1_mant_q[0]);
        endcase
        ovf_max = (s1_rm_q == 3'd1) || (s1_rm_q == 3'd2 && !s1_sign_q)
                  || (s1_rm_q == 3'd3 && s1_sign_q);
`else
        inc     = s1_g_q & (s1_s_q | s1_mant_q[0]);
        ovf_max = 1'b0;
`endif
        mant_sum = {1'b0, s1_mant_q} + {23'd0, inc};
        exp_r    = s1_exp_q + {{(EXP_W-1){1'b0}}, mant_sum[23]};
        nx       = s1_g_q | s1_s_q;
        res_d    = 32'h0;
        flags_d  = 5'h0;
        case (s1_class_q)
            3'd0: begin
                if (exp_r >= EXP_OVF) begin
                    flags_d = 5'b00101;
                    res_d   = ovf_max ? {s1_sign_q, 8'hFE, 23'h7FFFFF}
                                      : {s1_sign_q, 8'hFF, 23'h0};
                end else if (exp_r[EXP_W-1] || exp_r == '0) begin
                    flags_d = 5'b00011;
                    res_d   = {s1_sign_q, 31'h0};
                end else begin
                    flags_d = {4'b0, nx};
                    res_d   = {s1_sign_q, exp_r[7:0], mant_sum[22:0]};
                end
            end
            3'd1: res_d = {s1_sign_q, 31'h0};
            3'd2: res_d = {s1_sign_q, 8'hFF, 23'h0};
            3'd3: res_d = 32'h7FC00000;
            3'd5: begin
                res_d   = {s1_sign_q, 8'hFF, 23'h0};
                flags_d = 5'b01000;
            end
            default: begin
                res_d   = 32'h7FC00000;
                flags_d = 5'b10000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_class_q   <= 3'd0;
            s1_exp_q     <= '0;
            s1_mant_q    <= 23'd0;
            s1_g_q       <= 1'b0;
            s1_s_q       <= 1'b0;
`ifdef FPDIV_RM_EN
            s1_rm_q      <= 3'd0;
`endif
            s2_valid_q   <= 1'b0;
            out_result_q <= 32'h0;
            out_flags_q  <= 5'h0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q  <= in_sign;
                    s1_class_q <= in_class;
                    s1_exp_q   <= n_exp;
                    s1_mant_q  <= n_mant;
                    s1_g_q     <= n_g;
                    s1_s_q     <= n_s;
`ifdef FPDIV_RM_EN
                    s1_rm_q    <= rm;
`endif
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q <= res_d;
                    out_flags_q  <= flags_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_round_pack.sv
// Scoreboard bench for fpdiv_round_pack: directed cases, backpressure, reset, then random traffic
// checked against an arithmetic rounding model.
module tb_fpdiv_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [25:0] in_quot;
    logic        in_sticky;
    logic [2:0]  in_class;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
`ifdef FPDIV_RM_EN
    logic [2:0]  rm = 3'd0;
`endif

    logic [36:0] sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          bp_mode  = 0;

    fpdiv_round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_quot    (in_quot),
        .in_sticky  (in_sticky),
        .in_class   (in_class),
`ifdef FPDIV_RM_EN
        .rm         (rm),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: value = quot/2^25 * 2^(exp-127); keep 24 significant bits, round half to even.
    function automatic logic [36:0] model(input logic sg, input int ex, input logic [25:0] q,
                                          input logic st, input logic [2:0] c);
        longint keep, rem, half;
        int     e;
        bit     nx;
        logic [7:0]  e8;
        logic [22:0] m23;
        case (c)
            3'd1: return {5'b00000, sg, 31'h0};
            3'd2: return {5'b00000, sg, 8'hFF, 23'h0};
            3'd3: return {5'b00000, 32'h7FC00000};
            3'd5: return {5'b01000, sg, 8'hFF, 23'h0};
            3'd0: begin
                if (q >= 26'h2000000) begin
                    keep = longint'(q) / 4; rem = longint'(q) % 4; half = 2; e = ex;
                end else begin
                    keep = longint'(q) / 2; rem = longint'(q) % 2; half = 1; e = ex - 1;
                end
                nx = (rem != 0) || st;
                if (rem > half || (rem == half && (st || (keep % 2) == 1))) keep++;
                if (keep == (longint'(1) << 24)) begin
                    keep = keep / 2;
                    e++;
                end
                if (e >= 255) return {5'b00101, sg, 8'hFF, 23'h0};
                if (e <= 0)   return {5'b00011, sg, 31'h0};
                e8  = e[7:0];
                m23 = keep[22:0];
                return {4'b0000, nx, sg, e8, m23};
            end
            default: return {5'b10000, 32'h7FC00000};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_exp(input logic sg, input int ex, input logic [25:0] q, input logic st,
                            input logic [2:0] c, input logic [36:0] e);
        bit done = 0;
        in_valid  = 1'b1;
        in_sign   = sg;
        in_exp    = 10'(ex);
        in_quot   = q;
        in_sticky = st;
        in_class  = c;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic send(input logic sg, input int ex, input logic [25:0] q, input logic st,
                        input logic [2:0] c);
        send_exp(sg, ex, q, st, c, model(sg, ex, q, st, c));
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb_q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", out_result);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_result, e[31:0]);
                    chk("flags", 32'(out_flags), 32'(e[36:32]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] ea;
        int          edge_exp[7];
        edge_exp = '{-127, 0, 1, 2, 254, 255, 382};
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
        in_quot = '0; in_sticky = 1'b0; in_class = 3'd0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_exp(1'b0, 128, 26'h2000000, 1'b0, 3'd0, {5'b00000, 32'h40000000});
        chk("lat_after_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_after_2", 32'(out_valid), 32'd1);

        send_exp(1'b0, 127, 26'h1555555, 1'b1, 3'd0, {5'b00001, 32'h3F2AAAAB});
        send_exp(1'b0, 127, 26'h2000002, 1'b0, 3'd0, {5'b00001, 32'h3F800000});
        send_exp(1'b0, 127, 26'h2000006, 1'b0, 3'd0, {5'b00001, 32'h3F800002});
        send_exp(1'b0, 254, 26'h3FFFFFF, 1'b1, 3'd0, {5'b00101, 32'h7F800000});
        send_exp(1'b1, 0,   26'h2000000, 1'b0, 3'd0, {5'b00011, 32'h80000000});
        send_exp(1'b0, 0,   26'h0,       1'b0, 3'd4, {5'b10000, 32'h7FC00000});
        send_exp(1'b1, 0,   26'h0,       1'b0, 3'd5, {5'b01000, 32'hFF800000});
        send_exp(1'b0, 0,   26'h0,       1'b0, 3'd1, {5'b00000, 32'h00000000});
        drain();

        // Backpressure: A and B fill the pipe, C waits for release.
        bp_mode = 2; out_ready = 1'b0;
        @(negedge clk);
        ea = {5'b00001, 32'h3F2AAAAB};
        send_exp(1'b0, 127, 26'h1555555, 1'b1, 3'd0, ea);
        send_exp(1'b0, 127, 26'h2000006, 1'b0, 3'd0, {5'b00001, 32'h3F800002});
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_res", out_result, ea[31:0]);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("bp_hold_res", out_result, ea[31:0]);
            chk("bp_hold_flags", 32'(out_flags), 32'(ea[36:32]));
        end
        @(negedge clk);
        fork
            send(1'b1, 130, 26'h3000001, 1'b1, 3'd0);
            begin
                @(negedge clk);
                bp_mode = 0; out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two items in flight.
        bp_mode = 2; out_ready = 1'b0;
        @(negedge clk);
        send(1'b0, 100, 26'h2800000, 1'b0, 3'd0);
        send(1'b1, 140, 26'h1C00000, 1'b1, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0; bp_mode = 0; out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        send(1'b0, 127, 26'h2000000, 1'b0, 3'd0);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            int          r, ex;
            logic [2:0]  c;
            logic [25:0] q;
            r  = int'($urandom_range(0, 15));
            c  = (r < 9) ? 3'd0 : 3'(r - 8);
            ex = int'($urandom_range(0, 509)) - 127;
            if ($urandom_range(0, 5) == 0) ex = edge_exp[$urandom_range(0, 6)];
            q  = 26'($urandom_range(32'h3FFFFFF, 32'h1000000));
            if ($urandom_range(0, 7) == 0) q = ($urandom_range(0, 1) != 0) ? 26'h3FFFFFF : 26'h1FFFFFF;
            send(1'($urandom_range(0, 1)), ex, q, 1'($urandom_range(0, 1)), c);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        bp_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
